// File: rtl/bus_ram_ctrl.sv
// Single-port data RAM slave with a valid/ready request/response handshake, window decode and programmable read latency.
// Build option: define BUS_RAM_PARITY_EN for per-byte even parity, a par_inject input and a par_err_sticky output.
//
// state | meaning
// IDLE  | ready for a request (req_ready high once out of reset)
// WAIT  | latency countdown after accept
// RESP  | response presented, held until rsp_ready
module bus_ram_ctrl #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_1000,
    parameter int                RD_LAT    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
`ifdef BUS_RAM_PARITY_EN
    input  logic                par_inject,
    output logic                par_err_sticky,
`endif
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int WIN   = DEPTH * NB;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nx;
    logic [1:0]        cnt, cnt_nx;
    logic              ready_en;
    logic              accept;

    logic [ADDR_W-1:0] offset;
    logic              in_win;
    logic              aligned;
    logic              hit;
    logic [IDX_W-1:0]  idx;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_rd;
    logic              par_bad;

    logic [DATA_W-1:0] data_q;
    logic              err_q;

    // Offset-based window check cannot overflow even when the window ends at the top of the address space.
    assign offset  = req_addr - BASE_ADDR;
    assign in_win  = (req_addr >= BASE_ADDR) && (offset < ADDR_W'(WIN));
    assign aligned = (offset & ADDR_W'(NB - 1)) == '0;
    assign hit     = in_win && aligned;
    assign idx     = IDX_W'(offset >> OFF_W);
    assign mem_rd  = mem[idx];
    assign accept  = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (accept && hit && req_we) begin
            for (int i = 0; i < NB; i++) begin
                if (req_be[i]) begin
                    mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef BUS_RAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] wr_par;
    logic [NB-1:0] rd_par;

    always_comb begin
        wr_par = '0;
        rd_par = '0;
        for (int i = 0; i < NB; i++) begin
            wr_par[i] = (^req_wdata[8*i +: 8]) ^ par_inject;
            rd_par[i] = ^mem_rd[8*i +: 8];
        end
    end

    assign par_bad = hit && !req_we && (rd_par != par_mem[idx]);

    always_ff @(posedge clk) begin
        if (accept && hit && req_we) begin
            for (int i = 0; i < NB; i++) begin
                if (req_be[i]) begin
                    par_mem[idx][i] <= wr_par[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_err_sticky <= 1'b0;
        end else if (accept && par_bad) begin
            par_err_sticky <= 1'b1;
        end
    end
`else
    assign par_bad = 1'b0;
`endif

    // The array is sampled at accept; the result is held until the response handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            data_q <= (hit && !req_we) ? mem_rd : '0;
            err_q  <= !hit || par_bad;
        end
    end

    // ready_en keeps req_ready low through reset and for the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = ready_en;
                if (req_valid && ready_en) begin
                    if (RD_LAT == 1) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = 2'(RD_LAT - 1);
                    end
                end
            end
            WAIT: begin
                cnt_nx = cnt - 2'd1;
                if (cnt == 2'd1) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign rsp_rdata = rsp_valid ? data_q : '0;
    assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_bus_ram_ctrl.sv
// Directed bench for bus_ram_ctrl: one instance with RD_LAT=1 and one with RD_LAT=3, both at BASE 0x1000, DEPTH 256.
// Parity checks are compiled in when BUS_RAM_PARITY_EN is defined.
module tb_bus_ram_ctrl;

    logic        clk;
    logic        rst;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        par_inject;

    logic        req_valid1, req_valid3;
    logic        req_ready1, req_ready3;
    logic        rsp_valid1, rsp_valid3;
    logic        rsp_ready1, rsp_ready3;
    logic [31:0] rsp_rdata1, rsp_rdata3;
    logic        rsp_err1, rsp_err3;
    logic        sticky1, sticky3;

    int n_checks = 0;
    int n_pass   = 0;

    bus_ram_ctrl #(.RD_LAT(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid1),
        .req_ready (req_ready1),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid1),
        .rsp_ready (rsp_ready1),
`ifdef BUS_RAM_PARITY_EN
        .par_inject     (par_inject),
        .par_err_sticky (sticky1),
`endif
        .rsp_rdata (rsp_rdata1),
        .rsp_err   (rsp_err1)
    );

    bus_ram_ctrl #(.RD_LAT(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid3),
        .req_ready (req_ready3),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid3),
        .rsp_ready (rsp_ready3),
`ifdef BUS_RAM_PARITY_EN
        .par_inject     (par_inject),
        .par_err_sticky (sticky3),
`endif
        .rsp_rdata (rsp_rdata3),
        .rsp_err   (rsp_err3)
    );

`ifndef BUS_RAM_PARITY_EN
    assign sticky1 = 1'b0;
    assign sticky3 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one request, wait for the accept edge, then count edges until rsp_valid.
    task automatic issue(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input int exp_lat,
                         output logic [31:0] rdata, output logic err);
        int   n;
        logic v;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        if (d == 1) req_valid1 = 1'b1;
        else        req_valid3 = 1'b1;
        check("ready_at_req", (d == 1) ? req_ready1 : req_ready3, 32'd1);
        @(posedge clk);
        #1;
        req_valid1 = 1'b0;
        req_valid3 = 1'b0;
        req_addr   = 32'hFFFF_FFFC;
        req_wdata  = 32'h5A5A_5A5A;
        req_be     = 4'h0;
        n = 1;
        v = (d == 1) ? rsp_valid1 : rsp_valid3;
        while (!v && n < 12) begin
            @(posedge clk);
            #1;
            n++;
            v = (d == 1) ? rsp_valid1 : rsp_valid3;
        end
        check("latency", n, exp_lat);
        rdata = (d == 1) ? rsp_rdata1 : rsp_rdata3;
        err   = (d == 1) ? rsp_err1 : rsp_err3;
    endtask

    task automatic handshake(input int d);
        @(posedge clk);
        #1;
        check("valid_after_hs", (d == 1) ? rsp_valid1 : rsp_valid3, 32'd0);
        check("ready_after_hs", (d == 1) ? req_ready1 : req_ready3, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          cnt;

        rst        = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_be     = '0;
        par_inject = 1'b0;
        req_valid1 = 1'b0;
        req_valid3 = 1'b0;
        rsp_ready1 = 1'b1;
        rsp_ready3 = 1'b1;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", rsp_valid1, 32'd0);
        check("rst_rdata", rsp_rdata1, 32'd0);
        check("rst_err", rsp_err1, 32'd0);
        check("rst_ready", req_ready1, 32'd0);
        rst = 1'b1;
        #1;
        check("ready_before_edge", req_ready1, 32'd0);
        @(posedge clk);
        #1;
        check("ready_after_rel1", req_ready1, 32'd1);
        check("ready_after_rel3", req_ready3, 32'd1);

        // full write then read
        issue(1, 1'b1, 32'h1004, 32'hDEAD_BEEF, 4'hF, 1, rd, er);
        check("wr_rdata", rd, 32'd0);
        check("wr_err", er, 32'd0);
        handshake(1);
        issue(1, 1'b0, 32'h1004, 32'h0, 4'h0, 1, rd, er);
        check("rd_data", rd, 32'hDEAD_BEEF);
        check("rd_err", er, 32'd0);
        handshake(1);

        // byte-lane write
        issue(1, 1'b1, 32'h1004, 32'h0000_AA00, 4'b0010, 1, rd, er);
        handshake(1);
        issue(1, 1'b0, 32'h1004, 32'h0, 4'hF, 1, rd, er);
        check("partial_rd", rd, 32'hDEAD_AAEF);
        handshake(1);

        // be=0 write is a no-op without error
        issue(1, 1'b1, 32'h1004, 32'h1234_5678, 4'h0, 1, rd, er);
        check("be0_err", er, 32'd0);
        handshake(1);
        issue(1, 1'b0, 32'h1004, 32'h0, 4'h0, 1, rd, er);
        check("be0_rd", rd, 32'hDEAD_AAEF);
        handshake(1);

        // window edges and decode errors
        issue(1, 1'b1, 32'h1000, 32'h1122_3344, 4'hF, 1, rd, er);
        handshake(1);
        issue(1, 1'b1, 32'h13FC, 32'h0BAD_F00D, 4'hF, 1, rd, er);
        check("last_wr_err", er, 32'd0);
        handshake(1);
        issue(1, 1'b0, 32'h13FC, 32'h0, 4'h0, 1, rd, er);
        check("last_rd", rd, 32'h0BAD_F00D);
        handshake(1);
        issue(1, 1'b0, 32'h0FFC, 32'h0, 4'h0, 1, rd, er);
        check("below_err", er, 32'd1);
        check("below_rdata", rd, 32'd0);
        handshake(1);
        issue(1, 1'b0, 32'h1400, 32'h0, 4'h0, 1, rd, er);
        check("above_err", er, 32'd1);
        check("above_rdata", rd, 32'd0);
        handshake(1);
        issue(1, 1'b0, 32'h1002, 32'h0, 4'h0, 1, rd, er);
        check("misalign_err", er, 32'd1);
        check("misalign_rdata", rd, 32'd0);
        handshake(1);
        issue(1, 1'b1, 32'h1400, 32'hFFFF_FFFF, 4'hF, 1, rd, er);
        check("oow_wr_err", er, 32'd1);
        handshake(1);
        issue(1, 1'b0, 32'h1000, 32'h0, 4'h0, 1, rd, er);
        check("word0_intact", rd, 32'h1122_3344);
        check("word0_err", er, 32'd0);
        handshake(1);

        // RD_LAT=3 with backpressure
        issue(3, 1'b1, 32'h1010, 32'hCAFE_F00D, 4'hF, 3, rd, er);
        handshake(3);
        rsp_ready3 = 1'b0;
        issue(3, 1'b0, 32'h1010, 32'h0, 4'h0, 3, rd, er);
        check("lat3_rd", rd, 32'hCAFE_F00D);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", rsp_valid3, 32'd1);
            check("bp_rdata", rsp_rdata3, 32'hCAFE_F00D);
            check("bp_ready", req_ready3, 32'd0);
        end
        rsp_ready3 = 1'b1;
        handshake(3);
        issue(3, 1'b0, 32'h1000, 32'h0, 4'h0, 3, rd, er);
        check("lat3_oow_free", er, 32'd0);
        handshake(3);
        issue(3, 1'b0, 32'h1002, 32'h0, 4'h0, 3, rd, er);
        check("lat3_err", er, 32'd1);
        handshake(3);

        // reset while waiting on a read
        req_we     = 1'b0;
        req_addr   = 32'h1010;
        req_be     = 4'h0;
        req_valid3 = 1'b1;
        @(posedge clk);
        #1;
        req_valid3 = 1'b0;
        check("wait_no_valid", rsp_valid3, 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_valid", rsp_valid3, 32'd0);
        check("midrst_ready", req_ready3, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid3) cnt++;
        end
        check("no_rsp_after_rst", cnt, 32'd0);
        check("idle_after_rst", req_ready3, 32'd1);
        issue(3, 1'b0, 32'h1010, 32'h0, 4'h0, 3, rd, er);
        check("write_survives_rst", rd, 32'hCAFE_F00D);
        handshake(3);

`ifdef BUS_RAM_PARITY_EN
        check("sticky_clear", sticky1, 32'd0);
        par_inject = 1'b1;
        issue(1, 1'b1, 32'h1008, 32'h1234_5678, 4'hF, 1, rd, er);
        par_inject = 1'b0;
        check("inj_wr_err", er, 32'd0);
        handshake(1);
        issue(1, 1'b0, 32'h1008, 32'h0, 4'h0, 1, rd, er);
        check("par_rdata", rd, 32'h1234_5678);
        check("par_err", er, 32'd1);
        handshake(1);
        check("sticky_set", sticky1, 32'd1);
        check("sticky3_clear", sticky3, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_ram_ctrl.md
Name: bus_ram_ctrl

Overview:
Parametrised on-chip data RAM slave for the CPU data bus, replacing the fixed 100-word RAM peripheral. It adds a configurable base address, depth, width and read latency, per-byte write strobes, and a valid/ready request/response handshake. Out-of-window and misaligned accesses return an explicit error instead of driving Z. It sits on the CPU data bus beside GPIO and other memory-mapped peripherals.

Parameters:
DATA_W, 32, data width in bits; multiple of 8, minimum 8.
ADDR_W, 32, bus byte-address width.
DEPTH, 256, number of DATA_W words; power of two, minimum 2.
BASE_ADDR, 32'h0000_1000, byte address of word 0; aligned to DEPTH*DATA_W/8.
RD_LAT, 1, cycles from request acceptance to rsp_valid; legal range 1..4.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  reset, asynchronous, active-low.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request.
req_we  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  write data.
req_be  in  DATA_W/8  byte enables; bit i controls byte i.
rsp_valid  out  1  response present.
rsp_ready  in  1  master accepts the response.
rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
rsp_err  out  1  access error flag, qualified by rsp_valid.

Behaviour:
- Reset values: req_ready=0 while rst=0; rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE, latency counter=0. Memory array is not reset.
- Accept: a request is accepted on a posedge where req_valid && req_ready. Only one transaction is outstanding at a time.
- FSM states:
  - IDLE (req_ready=1): on accept -> WAIT, counter loaded with RD_LAT-1. If RD_LAT=1, go directly to RESP.
  - WAIT (req_ready=0): counter decrements each cycle; at 0 -> RESP.
  - RESP (rsp_valid=1, req_ready=0): outputs are held stable until rsp_ready=1; on that edge -> IDLE.
- Timing: rsp_valid rises exactly RD_LAT cycles after the accept edge. Back-to-back throughput is RD_LAT+1 cycles per access when rsp_ready is held at 1.
- Decode:
  - word index = (req_addr - BASE_ADDR) >> log2(DATA_W/8).
  - Hit when BASE_ADDR <= req_addr <= BASE_ADDR + DEPTH*DATA_W/8 - 1 and the low log2(DATA_W/8) address bits are 0.
  - Otherwise error: rsp_err=1, rsp_rdata=0, no array access, same latency as a hit.
- Write:
  - Committed on the accept edge for each byte with req_be[i]=1; other bytes are unchanged.
  - req_be=0 is a legal no-op and returns rsp_err=0.
  - Response: rsp_rdata=0, rsp_err=0 on a hit.
- Read:
  - Array is sampled on the accept edge; data is carried through the latency stages.
  - req_be is ignored.
  - A read of a never-written word returns X (simulation only).
- Request fields are captured at the accept edge; changes to them afterwards have no effect.
- rsp_ready=1 while rsp_valid=0 is ignored.
- Reset mid-operation: the FSM aborts to IDLE, the pending response is discarded, and rsp_valid drops asynchronously. A write accepted before reset stays committed.

Optional Feature:
Macro BUS_RAM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte, written alongside the data byte.
  - On a read hit, parity is recomputed; any mismatch sets rsp_err=1 but still returns the data.
  - Extra input par_inject (1 bit): when 1 at a write accept, the stored parity of every written byte is inverted.
  - Extra output par_err_sticky (1 bit): set on any read parity mismatch, cleared only by reset.
- Undefined:
  - No parity storage, no extra ports.
  - rsp_err reflects decode errors only.

Test Plan:
1. Reset values, RD_LAT=1, BASE=0x1000: with rst=0 -> rsp_valid=0, rsp_rdata=0, req_ready=0; after rst=1 -> req_ready=1 on the next cycle.
2. Write then read: write 0x1004 data 0xDEADBEEF be=4'hF, then read 0x1004 -> rsp_valid exactly 1 cycle after accept, rdata=0xDEADBEEF, err=0.
3. Partial write: be=4'b0010 data 0x0000AA00 to 0x1004 -> subsequent read returns 0xDEADAAEF.
4. Decode errors: read 0x0FFC, read 0x1400 (DEPTH=256), read 0x1002 -> each returns err=1, rdata=0. A write to 0x1400 leaves word 0 unchanged.
5. Latency and backpressure, RD_LAT=3: rsp_valid appears exactly 3 cycles after accept; with rsp_ready held 0 for 5 cycles, outputs stay stable and req_ready=0; next request is accepted the cycle after the rsp_ready handshake.
6. Reset mid-read, plus parity: rst asserted in WAIT -> rsp_valid never rises and state returns to IDLE. With BUS_RAM_PARITY_EN, write 0x1008 with par_inject=1 -> read returns the data with err=1 and par_err_sticky=1.
